ex_stage: RTL and testbench

//  Execute stage between the ID/EX pipeline register and MEM. Forwards operands, runs the ALU,
//  and runs multi-cycle RV32M mul/div through an iterative unit. Holds ID/EX via stall_req

---
 rtl/ex_pkg.sv | 46 ++++
 rtl/ex_stage_muldiv.sv | 149 ++++++++++++++
 rtl/ex_stage.sv | 180 ++++++++++++++++++
 tb/tb_ex_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared opcodes, control-bundle bit positions and mul/div FSM states
// for the execute stage.
package ex_pkg;

   localparam int DP_W       = 11;
   localparam int DP_IMM_SEL = 0;
   localparam int DP_PC_SEL  = 1;
   localparam int DP_REG_WE  = 2;

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_SLL   = 5'd2;
   localparam logic [4:0] OP_SLT   = 5'd3;
   localparam logic [4:0] OP_SLTU  = 5'd4;
   localparam logic [4:0] OP_XOR   = 5'd5;
   localparam logic [4:0] OP_SRL   = 5'd6;
   localparam logic [4:0] OP_SRA   = 5'd7;
   localparam logic [4:0] OP_OR    = 5'd8;
   localparam logic [4:0] OP_AND   = 5'd9;
   localparam logic [4:0] OP_PASSB = 5'd10;

   localparam logic [4:0] OP_MUL    = 5'd16;
   localparam logic [4:0] OP_MULH   = 5'd17;
   localparam logic [4:0] OP_MULHSU = 5'd18;
   localparam logic [4:0] OP_MULHU  = 5'd19;
   localparam logic [4:0] OP_DIV    = 5'd20;
   localparam logic [4:0] OP_DIVU   = 5'd21;
   localparam logic [4:0] OP_REM    = 5'd22;
   localparam logic [4:0] OP_REMU   = 5'd23;

   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/ex_stage_muldiv.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on operand
// magnitudes, one result bit per cycle, sign-corrected on the way out.
module muldiv_iter
   import ex_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MD_ITER = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int              CW       = $clog2(MD_ITER);
   localparam logic [CW-1:0]   CNT_LAST = CW'(MD_ITER - 1);
   localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] dv_q, dv_d;
   logic            neg_q, neg_d;
   logic            rneg_q, rneg_d;
   logic            div0_q, div0_d;
   logic            ovf_q, ovf_d;

   logic              a_signed, b_signed, sa, sb;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN:0]     sum, rem_sh;
   logic              ge;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo_s, rem_s;

   always_comb begin
      a_signed = (op == MD_MULH) | (op == MD_MULHSU) |
                 (op == MD_DIV) | (op == MD_REM);
      b_signed = (op == MD_MULH) | (op == MD_DIV) | (op == MD_REM);
      sa = a_signed & a[XLEN-1];
      sb = b_signed & b[XLEN-1];
      a_mag = sa ? -a : a;
      b_mag = sb ? -b : b;
   end

   // hi:lo is the product for mul, remainder:quotient for div
   always_comb begin
      sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
      rem_sh = {hi_q, lo_q[XLEN-1]};
      ge     = rem_sh >= {1'b0, dv_q};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dv_d    = dv_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      div0_d  = div0_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         MD_IDLE: begin
            if (start) begin
               state_d = MD_BUSY;
               cnt_d   = '0;
               op_d    = op;
               hi_d    = '0;
               lo_d    = op[2] ? a_mag : b_mag;
               dv_d    = op[2] ? b_mag : a_mag;
               neg_d   = sa ^ sb;
               rneg_d  = sa;
               div0_d  = op[2] & (b == '0);
               ovf_d   = op[2] & ~op[0] & (a == SMIN) & (&b);
            end
         end
         MD_BUSY: begin
            if (op_q[2]) begin
               hi_d = ge ? (rem_sh[XLEN-1:0] - dv_q) : rem_sh[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], ge};
            end else begin
               hi_d = sum[XLEN:1];
               lo_d = {sum[0], lo_q[XLEN-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = MD_DONE;
         end
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
      if (kill) state_d = MD_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dv_q    <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div0_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dv_q    <= dv_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         div0_q  <= div0_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      prod   = {hi_q, lo_q};
      prod_s = neg_q ? -prod : prod;
      quo_s  = neg_q ? -lo_q : lo_q;
      rem_s  = rneg_q ? -hi_q : hi_q;
      result = '0;
      unique case (op_q)
         MD_MUL:                       result = prod_s[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: result = prod_s[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:
            result = div0_q ? '1 : (ovf_q ? SMIN : quo_s);
         MD_REM, MD_REMU:
            result = ovf_q ? '0 : rem_s;
         default:                      result = '0;
      endcase
   end

   assign busy = (state_q == MD_BUSY);
   assign done = (state_q == MD_DONE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative mul/div
// with upstream stall, registered EX/MEM outputs.
module ex_stage
   import ex_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MD_ITER = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            id_bubble,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_imm,
   input  logic [XLEN-1:0] id_rs1_val,
   input  logic [XLEN-1:0] id_rs2_val,
   input  logic [4:0]      id_alu_op,
   input  logic [DP_W-1:0] id_datapath,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_val,
   output logic            stall_req,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_result,
   output logic [XLEN-1:0] ex_store,
   output logic [4:0]      ex_rd,
   output logic [XLEN-1:0] ex_pc,
   output logic [DP_W-1:0] ex_datapath
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] store_q, store_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [DP_W-1:0] dp_q, dp_d;

   logic [4:0]      hold_rd_q, hold_rd_d;
   logic [XLEN-1:0] hold_pc_q, hold_pc_d;
   logic [XLEN-1:0] hold_st_q, hold_st_d;
   logic [DP_W-1:0] hold_dp_q, hold_dp_d;

   logic            is_md, md_busy, md_done, md_idle, md_start;
   logic [XLEN-1:0] md_result;
   logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_res;
   logic [4:0]      shamt;
   logic            exm_fwd;

   assign is_md = (id_alu_op[4:3] == 2'b10);

   // EX/MEM beats MEM/WB since it holds the younger write
   always_comb begin
      exm_fwd = valid_q & dp_q[DP_REG_WE] & (rd_q != 5'd0);
      fwd_rs1 = id_rs1_val;
      fwd_rs2 = id_rs2_val;
      if (exm_fwd && rd_q == id_rs1)
         fwd_rs1 = result_q;
      else if (wb_we && wb_rd != 5'd0 && wb_rd == id_rs1)
         fwd_rs1 = wb_val;
      if (exm_fwd && rd_q == id_rs2)
         fwd_rs2 = result_q;
      else if (wb_we && wb_rd != 5'd0 && wb_rd == id_rs2)
         fwd_rs2 = wb_val;
      op_a  = id_datapath[DP_PC_SEL] ? id_pc : fwd_rs1;
      op_b  = id_datapath[DP_IMM_SEL] ? id_imm : fwd_rs2;
      shamt = op_b[4:0];
   end

   always_comb begin
      alu_res = '0;
      case (id_alu_op)
         OP_ADD:   alu_res = op_a + op_b;
         OP_SUB:   alu_res = op_a - op_b;
         OP_SLL:   alu_res = op_a << shamt;
         OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         OP_XOR:   alu_res = op_a ^ op_b;
         OP_SRL:   alu_res = op_a >> shamt;
         OP_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
         OP_OR:    alu_res = op_a | op_b;
         OP_AND:   alu_res = op_a & op_b;
         OP_PASSB: alu_res = op_b;
         default:  alu_res = '0;
      endcase
   end

   muldiv_iter #(
      .XLEN    (XLEN),
      .MD_ITER (MD_ITER)
   ) u_md (
      .clk    (clk),
      .rst    (rst),
      .start  (md_start),
      .kill   (flush),
      .op     (id_alu_op[2:0]),
      .a      (fwd_rs1),
      .b      (fwd_rs2),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );

   assign md_idle   = ~md_busy & ~md_done;
   assign md_start  = md_idle & is_md & ~id_bubble & ~flush;
   assign stall_req = ~rst & ~flush &
                      (md_busy | (md_idle & is_md & ~id_bubble));

   always_comb begin
      valid_d   = 1'b0;
      result_d  = '0;
      store_d   = '0;
      rd_d      = '0;
      pc_d      = '0;
      dp_d      = '0;
      hold_rd_d = hold_rd_q;
      hold_pc_d = hold_pc_q;
      hold_st_d = hold_st_q;
      hold_dp_d = hold_dp_q;
      if (!flush) begin
         if (md_done) begin
            valid_d  = 1'b1;
            result_d = md_result;
            store_d  = hold_st_q;
            rd_d     = hold_rd_q;
            pc_d     = hold_pc_q;
            dp_d     = hold_dp_q;
         end else if (md_idle && !id_bubble && !is_md) begin
            valid_d  = 1'b1;
            result_d = alu_res;
            store_d  = fwd_rs2;
            rd_d     = id_rd;
            pc_d     = id_pc;
            dp_d     = id_datapath;
         end
      end
      if (md_start) begin
         hold_rd_d = id_rd;
         hold_pc_d = id_pc;
         hold_st_d = fwd_rs2;
         hold_dp_d = id_datapath;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         result_q  <= '0;
         store_q   <= '0;
         rd_q      <= '0;
         pc_q      <= '0;
         dp_q      <= '0;
         hold_rd_q <= '0;
         hold_pc_q <= '0;
         hold_st_q <= '0;
         hold_dp_q <= '0;
      end else begin
         valid_q   <= valid_d;
         result_q  <= result_d;
         store_q   <= store_d;
         rd_q      <= rd_d;
         pc_q      <= pc_d;
         dp_q      <= dp_d;
         hold_rd_q <= hold_rd_d;
         hold_pc_q <= hold_pc_d;
         hold_st_q <= hold_st_d;
         hold_dp_q <= hold_dp_d;
      end
   end

   assign ex_valid    = valid_q;
   assign ex_result   = result_q;
   assign ex_store    = store_q;
   assign ex_rd       = rd_q;
   assign ex_pc       = pc_q;
   assign ex_datapath = dp_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table plus scoreboard queue, with
// hand-written forwarding, flush and reset sequences.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst, flush, id_bubble;
   logic [4:0]  id_rs1, id_rs2, id_rd, id_alu_op;
   logic [31:0] id_pc, id_imm, id_rs1_val, id_rs2_val;
   logic [10:0] id_datapath;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_val;
   logic        stall_req, ex_valid;
   logic [31:0] ex_result, ex_store, ex_pc;
   logic [4:0]  ex_rd;
   logic [10:0] ex_datapath;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] res;
      logic [31:0] st;
      logic [4:0]  rd;
   } sb_t;
   sb_t sbq[$];

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [10:0] dp;
      logic [31:0] exp;
      int          stalls;
   } vec_t;
   vec_t tbl[$];

   ex_stage dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .id_bubble   (id_bubble),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rd       (id_rd),
      .id_pc       (id_pc),
      .id_imm      (id_imm),
      .id_rs1_val  (id_rs1_val),
      .id_rs2_val  (id_rs2_val),
      .id_alu_op   (id_alu_op),
      .id_datapath (id_datapath),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_val      (wb_val),
      .stall_req   (stall_req),
      .ex_valid    (ex_valid),
      .ex_result   (ex_result),
      .ex_store    (ex_store),
      .ex_rd       (ex_rd),
      .ex_pc       (ex_pc),
      .ex_datapath (ex_datapath)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && ex_valid) begin
         if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid: got result %h expected none",
                     ex_result);
         end else begin
            sb_t e;
            e = sbq.pop_front();
            check("sb_result", ex_result, e.res);
            check("sb_store", ex_store, e.st);
            check("sb_rd", {27'd0, ex_rd}, {27'd0, e.rd});
         end
      end
   end

   // Presents one instruction and holds it until the stage stops stalling.
   task automatic issue(input logic [4:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic [10:0] dp, input logic [31:0] exp_res,
                        input logic [31:0] exp_st, input int exp_stalls);
      int  stalls;
      sb_t e;
      id_alu_op   = op;
      id_rs1      = rs1;
      id_rs2      = rs2;
      id_rd       = rd;
      id_rs1_val  = v1;
      id_rs2_val  = v2;
      id_imm      = imm;
      id_pc       = pc;
      id_datapath = dp;
      id_bubble   = 1'b0;
      stalls      = 0;
      forever begin
         @(negedge clk);
         if (!stall_req) break;
         stalls++;
         if (stalls > 200) break;
      end
      if (stalls > 200) begin
         n_tests++;
         n_fail++;
         $display("FAIL issue_timeout: got >200 stalls expected %0d",
                  exp_stalls);
      end else begin
         e.res = exp_res;
         e.st  = exp_st;
         e.rd  = rd;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      id_bubble = 1'b1;
      check("stall_cycles", stalls, exp_stalls);
      check("valid_after_accept", {31'd0, ex_valid}, 32'd1);
   endtask

   function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm,
                               input logic [31:0] pc, input logic [10:0] dp,
                               input logic [31:0] exp);
      vec_t v;
      v.op     = op;
      v.a      = a;
      v.b      = b;
      v.imm    = imm;
      v.pc     = pc;
      v.dp     = dp;
      v.exp    = exp;
      v.stalls = (op >= 5'd16) ? 33 : 0;
      return v;
   endfunction

   initial begin
      tbl.push_back(mk(5'd0,  32'd5, 32'd7, 0, 0, 11'h4, 32'd12));
      tbl.push_back(mk(5'd1,  32'd5, 32'd7, 0, 0, 11'h4, 32'hFFFFFFFE));
      tbl.push_back(mk(5'd2,  32'd1, 32'd33, 0, 0, 11'h4, 32'd2));
      tbl.push_back(mk(5'd3,  32'hFFFFFFFF, 32'd1, 0, 0, 11'h4, 32'd1));
      tbl.push_back(mk(5'd4,  32'hFFFFFFFF, 32'd1, 0, 0, 11'h4, 32'd0));
      tbl.push_back(mk(5'd5,  32'hF0F0, 32'hFF00, 0, 0, 11'h4, 32'h0FF0));
      tbl.push_back(mk(5'd6,  32'h80000000, 32'd31, 0, 0, 11'h4, 32'd1));
      tbl.push_back(mk(5'd7,  32'h80000000, 32'd4, 0, 0, 11'h4, 32'hF8000000));
      tbl.push_back(mk(5'd8,  32'hF0, 32'h0F, 0, 0, 11'h4, 32'hFF));
      tbl.push_back(mk(5'd9,  32'hF0, 32'h3C, 0, 0, 11'h4, 32'h30));
      tbl.push_back(mk(5'd10, 32'd1, 32'd2, 32'h12345000, 0, 11'h5,
                       32'h12345000));
      tbl.push_back(mk(5'd11, 32'd1, 32'd2, 0, 0, 11'h4, 32'd0));
      tbl.push_back(mk(5'd0,  32'd9, 32'd2, 32'd4, 32'h100, 11'h7, 32'h104));
      tbl.push_back(mk(5'd16, 32'hFFFFFFFF, 32'd2, 0, 0, 11'h4, 32'hFFFFFFFE));
      tbl.push_back(mk(5'd19, 32'hFFFFFFFF, 32'd2, 0, 0, 11'h4, 32'd1));
      tbl.push_back(mk(5'd17, 32'hFFFFFFFF, 32'd2, 0, 0, 11'h4, 32'hFFFFFFFF));
      tbl.push_back(mk(5'd18, 32'hFFFFFFFF, 32'd2, 0, 0, 11'h4, 32'hFFFFFFFF));
      tbl.push_back(mk(5'd17, 32'h80000000, 32'h80000000, 0, 0, 11'h4,
                       32'h40000000));
      tbl.push_back(mk(5'd20, 32'd7, 32'd0, 0, 0, 11'h4, 32'hFFFFFFFF));
      tbl.push_back(mk(5'd22, 32'd7, 32'd0, 0, 0, 11'h4, 32'd7));
      tbl.push_back(mk(5'd22, 32'hFFFFFFEC, 32'd0, 0, 0, 11'h4, 32'hFFFFFFEC));
      tbl.push_back(mk(5'd20, 32'h80000000, 32'hFFFFFFFF, 0, 0, 11'h4,
                       32'h80000000));
      tbl.push_back(mk(5'd22, 32'h80000000, 32'hFFFFFFFF, 0, 0, 11'h4, 32'd0));
      tbl.push_back(mk(5'd22, 32'hFFFFFFF9, 32'd2, 0, 0, 11'h4, 32'hFFFFFFFF));
      tbl.push_back(mk(5'd20, 32'hFFFFFFF9, 32'd2, 0, 0, 11'h4, 32'hFFFFFFFD));
      tbl.push_back(mk(5'd23, 32'd100, 32'd7, 0, 0, 11'h4, 32'd2));

      rst = 1'b1;
      flush = 1'b0;
      id_bubble = 1'b1;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_op = '0;
      id_pc = '0; id_imm = '0; id_rs1_val = '0; id_rs2_val = '0;
      id_datapath = '0;
      wb_we = 1'b0; wb_rd = '0; wb_val = '0;
      #3;
      check("rst_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_result", ex_result, 32'd0);
      check("rst_pc", ex_pc, 32'd0);
      check("rst_dp", {21'd0, ex_datapath}, 32'd0);
      check("rst_stall", {31'd0, stall_req}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (tbl[i])
         issue(tbl[i].op, 5'd10, 5'd11, 5'd3, tbl[i].a, tbl[i].b,
               tbl[i].imm, tbl[i].pc, tbl[i].dp, tbl[i].exp, tbl[i].b,
               tbl[i].stalls);
      check("pc_passthru_last_alu", ex_pc, 32'd0);

      // back-to-back dependency: EX/MEM forward, then EX/MEM over MEM/WB
      issue(5'd0, 5'd10, 5'd11, 5'd1, 32'd3, 32'd4, 0, 0, 11'h4,
            32'd7, 32'd4, 0);
      issue(5'd0, 5'd1, 5'd1, 5'd2, 32'd0, 32'd0, 0, 0, 11'h4,
            32'd14, 32'd7, 0);
      issue(5'd0, 5'd10, 5'd11, 5'd1, 32'd3, 32'd4, 0, 0, 11'h4,
            32'd7, 32'd4, 0);
      wb_we = 1'b1; wb_rd = 5'd1; wb_val = 32'd9;
      issue(5'd0, 5'd1, 5'd1, 5'd2, 32'd0, 32'd0, 0, 0, 11'h4,
            32'd14, 32'd7, 0);
      @(posedge clk);
      #1;
      wb_rd = 5'd5; wb_val = 32'd20;
      issue(5'd0, 5'd5, 5'd11, 5'd6, 32'd0, 32'd1, 0, 0, 11'h4,
            32'd21, 32'd1, 0);
      wb_we = 1'b0;

      // flush while the divider is at count 10
      id_alu_op = 5'd16; id_rs1 = 5'd10; id_rs2 = 5'd11; id_rd = 5'd3;
      id_rs1_val = 32'd6; id_rs2_val = 32'd7; id_datapath = 11'h4;
      id_bubble = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("busy_before_flush", {31'd0, stall_req}, 32'd1);
      flush = 1'b1;
      #1;
      check("flush_stall_comb", {31'd0, stall_req}, 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      id_bubble = 1'b1;
      #1;
      check("flush_valid", {31'd0, ex_valid}, 32'd0);
      check("flush_idle", {31'd0, stall_req}, 32'd0);
      issue(5'd0, 5'd10, 5'd11, 5'd3, 32'd40, 32'd2, 0, 0, 11'h4,
            32'd42, 32'd2, 0);

      // asynchronous reset in the middle of a divide
      id_alu_op = 5'd20; id_rs1 = 5'd10; id_rs2 = 5'd11; id_rd = 5'd3;
      id_rs1_val = 32'd50; id_rs2_val = 32'd3; id_datapath = 11'h4;
      id_bubble = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      check("busy_before_rst", {31'd0, stall_req}, 32'd1);
      rst = 1'b1;
      #1;
      check("arst_stall", {31'd0, stall_req}, 32'd0);
      check("arst_valid", {31'd0, ex_valid}, 32'd0);
      check("arst_result", ex_result, 32'd0);
      id_bubble = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("post_rst_idle", {31'd0, stall_req}, 32'd0);
      issue(5'd21, 5'd10, 5'd11, 5'd4, 32'd100, 32'd7, 0, 32'h40, 11'h4,
            32'd14, 32'd7, 33);
      check("divu_pc", ex_pc, 32'h40);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
